// File: rtl/iter_div.sv
// Iterative 32-bit radix-2 restoring divider (signed DIV / unsigned DIVU).
// One quotient bit per cycle; sign correction and divide-by-zero handling applied in a final FIX cycle.
module iter_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] dvd_q, dvd_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        zero_q, zero_d;
    logic [31:0] q_q, q_d;
    logic [31:0] r_q, r_d;
    logic        done_q, done_d;
    logic        divz_q, divz_d;

    logic [32:0] rem_sh;
    logic [32:0] diff;

    // Partial remainder is widened to 33 bits only for the trial subtract.
    assign rem_sh = {rem_q, quo_q[31]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        q_d     = q_q;
        r_d     = r_q;
        divz_d  = divz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = (is_signed && divisor[31]) ? (32'd0 - divisor) : divisor;
                    quo_d   = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
                    rem_d   = 32'd0;
                    qneg_d  = is_signed & (dividend[31] ^ divisor[31]);
                    rneg_d  = is_signed & dividend[31];
                    zero_d  = (divisor == 32'd0);
                    count_d = 6'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                count_d = count_q + 6'd1;
                if (count_q == 6'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (zero_q) begin
                    q_d = 32'hFFFF_FFFF;
                    r_d = dvd_q;
                end else begin
                    q_d = qneg_q ? (32'd0 - quo_q) : quo_q;
                    r_d = rneg_q ? (32'd0 - rem_q) : rem_q;
                end
                divz_d  = zero_q;
                done_d  = 1'b1;
                count_d = 6'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            dvd_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            q_q     <= 32'd0;
            r_q     <= 32'd0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    assign q        = q_q;
    assign r        = r_q;
    assign done     = done_q;
    assign div_zero = divz_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 Parameter: none; datapath fixed at 32-bit operands, 32-bit quotient and remainder.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; all state cleared while low.
REQ-004 start  input  1  request pulse; operands and is_signed sampled on the edge where start=1 and busy=0.
REQ-005 is_signed  input  1  1 = signed division (DIV), 0 = unsigned (DIVU).
REQ-006 dividend  input  32  numerator.
REQ-007 divisor  input  32  denominator.
REQ-008 q  output  32  quotient, registered.
REQ-009 r  output  32  remainder, registered.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 done  output  1  one-cycle pulse marking q/r valid.
REQ-012 div_zero  output  1  high with done when divisor was zero; held until next accepted start.

Function
REQ-013 States: IDLE, CALC, FIX; one-hot or encoded, no other reachable states.
REQ-014 IDLE: on start=1, latch operands and mode; signed mode converts both operands to magnitudes and records quotient sign (dividend[31]^divisor[31]) and remainder sign (dividend[31]); go to CALC with 6-bit count=0; busy=1 from that edge.
REQ-015 CALC: radix-2 restoring step per cycle on 33-bit partial remainder: shift {rem,quo} left 1, trial-subtract divisor magnitude, keep difference and set quotient LSB=1 if non-negative, else restore and set LSB=0.
REQ-016 CALC runs exactly 32 cycles (count 0..31), then FIX.
REQ-017 FIX: apply sign correction (negate quotient if quotient sign set, negate remainder if remainder sign set), load q/r, pulse done=1, clear busy, return to IDLE, all on one edge.
REQ-018 Latency: start accepted at edge E -> done high in the cycle following edge E+33; busy high for cycles after E through E+32.
REQ-019 q, r, div_zero hold their values from done until the next accepted start; they are not cleared at start.
REQ-020 start while busy=1 is ignored; no queuing, operands not re-sampled.
REQ-021 start asserted in the same cycle done is high is accepted (busy already 0), enabling back-to-back operations every 34 cycles.
REQ-022 Divisor zero: full latency still taken; result q=32'hFFFFFFFF, r=dividend (original, unmodified), div_zero=1, in both modes.
REQ-023 Signed overflow 32'h80000000 / 32'hFFFFFFFF: q=32'h80000000, r=0, div_zero=0.
REQ-024 Signed results truncate toward zero; remainder carries sign of dividend; invariant dividend = q*divisor + r holds (mod 2^32) for all non-zero divisors.
REQ-025 Unsigned mode treats all operands as 0..2^32-1; no sign correction in FIX.
REQ-026 Magnitude of 32'h80000000 handled as unsigned 2^31 without overflow.

Reset
REQ-027 reset low asynchronously forces IDLE, q=0, r=0, busy=0, done=0, div_zero=0, count=0, internal registers 0.
REQ-028 reset low mid-CALC aborts the operation; no done pulse is produced after reset release.
REQ-029 First start is accepted on the first rising edge with reset high.

Verification
REQ-030 Unsigned: dividend=100, divisor=7, is_signed=0 -> done 34 cycles after start, q=14, r=2, div_zero=0.
REQ-031 Signed: dividend=-7 (32'hFFFFFFF9), divisor=2, is_signed=1 -> q=32'hFFFFFFFD (-3), r=32'hFFFFFFFF (-1); and 7/-2 -> q=-3, r=1.
REQ-032 Corner: 32'h80000000 / 32'hFFFFFFFF signed -> q=32'h80000000, r=0; same operands unsigned -> q=0, r=32'h80000000.
REQ-033 Divide-by-zero: dividend=32'h12345678, divisor=0 -> q=32'hFFFFFFFF, r=32'h12345678, div_zero=1 with done.
REQ-034 Protocol: start re-asserted at count=10 with new operands -> ignored, first result unchanged; start in done cycle -> second result exactly 34 cycles later.
REQ-035 Reset: reset low at count=20 -> busy/done/q/r=0 immediately, no done pulse within 40 cycles after release; plus 10k random signed/unsigned pairs checked against reference model.
